// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/update sequencing for a 5-stage pipe.
// Optional data-wait watchdog enabled by defining PIPE_WATCHDOG_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned WD_LIMIT = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        mem_req,
   input  logic        branch_taken,
   input  logic        load_use,
   input  logic        halt_mem,
   output logic        pc_en,
   output logic        ifid_update,
   output logic        idex_update,
   output logic        exmem_update,
   output logic        memwb_update,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        memwb_flush,
   output logic        halted,
   output logic        wd_timeout,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } state_t;

   // Latch vectors are ordered [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB.
   typedef struct packed {
      logic       pc_en;
      logic [3:0] upd;
      logic [3:0] fl;
   } ctrl_t;

   if (WD_LIMIT < 2 || WD_LIMIT > 65535) begin : g_bad_limit
      $error("pipeline_hazard_ctrl: WD_LIMIT must be in 2..65535");
   end

   state_t      state_q, state_d;
   ctrl_t       ctrl;
   logic        data_wait;
   logic        wd_trip;
   logic        count_en;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign data_wait = mem_req & ~dhit;

`ifdef PIPE_WATCHDOG_EN
   localparam logic [15:0] WD_LAST = 16'(WD_LIMIT - 1);

   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        wd_timeout_q, wd_timeout_d;

   assign wd_trip = (state_q == DWAIT) && data_wait && (wait_cnt_q == WD_LAST);

   // Counter is zero on the entry edge and on any edge that leaves DWAIT.
   always_comb begin
      wait_cnt_d = '0;
      if (state_q == DWAIT && state_d == DWAIT)
         wait_cnt_d = wait_cnt_q + 16'd1;
   end

   always_comb begin
      wd_timeout_d = wd_timeout_q | wd_trip;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wait_cnt_q   <= '0;
         wd_timeout_q <= 1'b0;
      end else begin
         wait_cnt_q   <= wait_cnt_d;
         wd_timeout_q <= wd_timeout_d;
      end
   end

   assign wd_timeout = wd_timeout_q;
`else
   assign wd_trip    = 1'b0;
   assign wd_timeout = 1'b0;
`endif

   always_comb begin
      ctrl    = '0;
      state_d = state_q;
      case (state_q)
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = RUN;
            // A taken branch with no fetch yet freezes exactly like a data wait,
            // but only a real data wait parks the FSM in DWAIT.
            if (data_wait || (branch_taken && !ihit)) begin
               ctrl.fl = 4'b0001;
               if (data_wait)
                  state_d = DWAIT;
            end else if (branch_taken) begin
               ctrl.pc_en = 1'b1;
               ctrl.fl    = 4'b1110;
               ctrl.upd   = 4'b0001;
            end else if (!ihit) begin
               ctrl.fl  = 4'b1000;
               ctrl.upd = 4'b0111;
            end else if (load_use) begin
               ctrl.fl  = 4'b0100;
               ctrl.upd = 4'b0011;
            end else begin
               ctrl.pc_en = 1'b1;
               ctrl.upd   = 4'b1111;
            end
            if ((halt_mem && ctrl.upd[0]) || wd_trip)
               state_d = HALT;
         end
      endcase
      if (RST)
         ctrl = '0;
   end

   always_comb begin
      assert ((ctrl.upd & ctrl.fl) == 4'b0000);
   end

   assign count_en = (state_q != HALT) && !ctrl.pc_en;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (count_en && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pc_en        = ctrl.pc_en;
   assign ifid_update  = ctrl.upd[3];
   assign idex_update  = ctrl.upd[2];
   assign exmem_update = ctrl.upd[1];
   assign memwb_update = ctrl.upd[0];
   assign ifid_flush   = ctrl.fl[3];
   assign idex_flush   = ctrl.fl[2];
   assign exmem_flush  = ctrl.fl[1];
   assign memwb_flush  = ctrl.fl[0];
   assign halted       = (state_q == HALT);
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected control/status pushed per driven cycle.
module tb_pipeline_hazard_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit, dhit, mem_req, branch_taken, load_use, halt_mem;
   logic        pc_en, halted, wd_timeout;
   logic        ifid_update, idex_update, exmem_update, memwb_update;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic [31:0] stall_cnt;

   // ctrl = {pc_en, upd ifid/idex/exmem/memwb, flush ifid/idex/exmem/memwb}
   localparam logic [8:0] ADV  = 9'b1_1111_0000;
   localparam logic [8:0] FRZ  = 9'b0_0000_0001;
   localparam logic [8:0] BR   = 9'b1_0001_1110;
   localparam logic [8:0] FW   = 9'b0_0111_1000;
   localparam logic [8:0] LU   = 9'b0_0011_0100;
   localparam logic [8:0] ZERO = 9'b0_0000_0000;

   typedef struct packed {
      logic [8:0]  c;
      logic        h;
      logic        wd;
      logic [31:0] st;
   } obs_t;

   obs_t        sb_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic        exp_halt = 1'b0;
   logic        exp_wd = 1'b0;
   logic [31:0] exp_stall = '0;

   pipeline_hazard_ctrl #(.WD_LIMIT(4)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .branch_taken(branch_taken), .load_use(load_use), .halt_mem(halt_mem),
      .pc_en(pc_en), .ifid_update(ifid_update), .idex_update(idex_update),
      .exmem_update(exmem_update), .memwb_update(memwb_update),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .halted(halted), .wd_timeout(wd_timeout),
      .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic obs_t obs();
      obs_t o;
      o.c  = {pc_en, ifid_update, idex_update, exmem_update, memwb_update,
              ifid_flush, idex_flush, exmem_flush, memwb_flush};
      o.h  = halted;
      o.wd = wd_timeout;
      o.st = stall_cnt;
      return o;
   endfunction

   // s = {ihit, dhit, mem_req, branch_taken, load_use, halt_mem}
   task automatic drive(input logic [5:0] s, input logic [8:0] e);
      obs_t o;
      {ihit, dhit, mem_req, branch_taken, load_use, halt_mem} = s;
      o.c  = e;
      o.h  = exp_halt;
      o.wd = exp_wd;
      o.st = exp_stall;
      sb_q.push_back(o);
      if (!e[8] && !exp_halt) exp_stall++;
   endtask

   task automatic test_reset();
      obs_t g;
      @(negedge CLK);
      g = obs();
      n_chk++;
      if (g !== '0) begin
         n_err++;
         $display("FAIL reset: got c=%b h=%b wd=%b st=%0d, want all zero", g.c, g.h, g.wd, g.st);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   task automatic test_advance();
      obs_t o, g;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1; drive(6'b100000, ADV);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL advance[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
   endtask

   task automatic test_dwait();
      logic [5:0] s [5] = '{6'b101000, 6'b101000, 6'b101000, 6'b111000, 6'b100000};
      logic [8:0] e [5] = '{FRZ, FRZ, FRZ, ADV, ADV};
      obs_t o, g;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1; drive(s[i], e[i]);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL dwait[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
   endtask

   task automatic test_branch();
      logic [5:0] s [6] = '{6'b100100, 6'b100000, 6'b000100, 6'b000100, 6'b100100, 6'b100000};
      logic [8:0] e [6] = '{BR, ADV, FRZ, FRZ, BR, ADV};
      obs_t o, g;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK); #1; drive(s[i], e[i]);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL branch[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
   endtask

   task automatic test_load_use();
      logic [5:0] s [3] = '{6'b100010, 6'b100000, 6'b100010};
      logic [8:0] e [3] = '{LU, ADV, LU};
      obs_t o, g;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1; drive(s[i], e[i]);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL load_use[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
   endtask

   task automatic test_fetch_wait();
      logic [5:0] s [3] = '{6'b000000, 6'b000010, 6'b100000};
      logic [8:0] e [3] = '{FW, FW, ADV};
      obs_t o, g;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1; drive(s[i], e[i]);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL fetch_wait[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
   endtask

   // Priority mixes; halt_mem during a freeze must not halt.
   task automatic test_back_to_back();
      logic [5:0] s [6] = '{6'b001110, 6'b111110, 6'b101001, 6'b111010, 6'b100000, 6'b001000};
      logic [8:0] e [6] = '{FRZ, BR, FRZ, LU, ADV, FRZ};
      obs_t o, g;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK); #1; drive(s[i], e[i]);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
   endtask

   task automatic test_reset_mid_dwait();
      obs_t o, g;
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK); #1; drive(6'b101000, FRZ);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL rst_dwait_pre[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
      #2; RST = 1'b1; #1;
      g = obs(); n_chk++;
      if (g !== '0) begin
         n_err++;
         $display("FAIL rst_dwait_async: got c=%b h=%b wd=%b st=%0d, want all zero", g.c, g.h, g.wd, g.st);
      end
      exp_stall = '0;
      exp_halt  = 1'b0;
      exp_wd    = 1'b0;
      @(posedge CLK); #3;
      {ihit, dhit, mem_req, branch_taken, load_use, halt_mem} = 6'b111000;
      RST = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK); #1; drive(6'b111000, ADV);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL rst_dwait_post[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
   endtask

   task automatic test_halt();
      logic [5:0] s [5] = '{6'b100001, 6'b000000, 6'b101000, 6'b100100, 6'b010010};
      obs_t o, g;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1; drive(s[i], (i == 0) ? ADV : ZERO);
         if (i == 0) exp_halt = 1'b1;
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL halt[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
      #2; RST = 1'b1; #1;
      g = obs(); n_chk++;
      if (g !== '0) begin
         n_err++;
         $display("FAIL halt_rst_async: got c=%b h=%b wd=%b st=%0d, want all zero", g.c, g.h, g.wd, g.st);
      end
      exp_stall = '0;
      exp_halt  = 1'b0;
      exp_wd    = 1'b0;
      @(posedge CLK); #3;
      {ihit, dhit, mem_req, branch_taken, load_use, halt_mem} = 6'b100000;
      RST = 1'b0;
      @(posedge CLK); #1; drive(6'b100000, ADV);
      @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
      if (g !== o) begin
         n_err++;
         $display("FAIL halt_post_rst: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                  g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
      end
   endtask

   task automatic test_watchdog();
      obs_t o, g;
`ifdef PIPE_WATCHDOG_EN
      // One RUN entry cycle, then DWAIT cycles; the 4th DWAIT cycle trips.
      for (int i = 0; i < 7; i++) begin
         @(posedge CLK); #1; drive((i < 5) ? 6'b101000 : 6'b111000, (i < 5) ? FRZ : ZERO);
         if (i == 4) begin
            exp_halt = 1'b1;
            exp_wd   = 1'b1;
         end
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL watchdog[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
`else
      // Without the watchdog a data wait may last indefinitely.
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1; drive((i < 9) ? 6'b101000 : 6'b111000, (i < 9) ? FRZ : ADV);
         @(negedge CLK); o = sb_q.pop_front(); g = obs(); n_chk++;
         if (g !== o) begin
            n_err++;
            $display("FAIL no_watchdog[%0d]: got c=%b h=%b wd=%b st=%0d, want c=%b h=%b wd=%b st=%0d",
                     i, g.c, g.h, g.wd, g.st, o.c, o.h, o.wd, o.st);
         end
      end
`endif
   endtask

   initial begin
      RST = 1'b1;
      {ihit, dhit, mem_req, branch_taken, load_use, halt_mem} = 6'b100000;
      test_reset();
      test_advance();
      test_dwait();
      test_branch();
      test_load_use();
      test_fetch_wait();
      test_back_to_back();
      test_reset_mid_dwait();
      test_halt();
      test_watchdog();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter WD_LIMIT, default 256, data-wait cycles before watchdog trips (range 2..65535).
REQ-002 CLK  in  1  sole clock; all state changes on posedge CLK.
REQ-003 RST  in  1  one clock; reset is asynchronous and active-high.
REQ-004 ihit  in  1  instruction fetch completes this cycle.
REQ-005 dhit  in  1  data access of MEM-stage instruction completes this cycle.
REQ-006 mem_req  in  1  MEM-stage instruction is a load or store.
REQ-007 branch_taken  in  1  MEM-stage branch/jump resolved taken.
REQ-008 load_use  in  1  ID-stage instruction sources the register loaded by EX-stage instruction.
REQ-009 halt_mem  in  1  MEM-stage instruction is HALT.
REQ-010 pc_en  out  1  PC load enable.
REQ-011 ifid_update, idex_update, exmem_update, memwb_update  out  1 each  latch update enables.
REQ-012 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flush (bubble) strobes.
REQ-013 halted  out  1  sticky; pipeline stopped.
REQ-014 wd_timeout  out  1  sticky; watchdog tripped.
REQ-015 stall_cnt  out  32  cycles with pc_en=0 while not halted.

Function
REQ-016 FSM states RUN, DWAIT, HALT; update/flush/pc_en are combinational from state and inputs.
REQ-017 Per latch, update and flush shall never both be 1 in the same cycle.
REQ-018 Condition priority per cycle: HALT state > data wait > branch > fetch wait > load-use > advance.
REQ-019 Data wait (RUN/DWAIT, mem_req=1, dhit=0): pc_en=0, ifid/idex/exmem_update=0, memwb_flush=1, other flushes 0; next state DWAIT.
REQ-020 Branch (branch_taken=1, no data wait, ihit=1): pc_en=1, ifid/idex/exmem_flush=1, memwb_update=1; next RUN.
REQ-021 Branch with ihit=0: freeze as REQ-019 outputs; branch held in EX/MEM until ihit=1.
REQ-022 Fetch wait (ihit=0, no branch/data wait): pc_en=0, ifid_flush=1, idex/exmem/memwb_update=1.
REQ-023 Load-use (ihit=1, no higher condition): pc_en=0, ifid_update=0, idex_flush=1, exmem/memwb_update=1.
REQ-024 Advance: pc_en=1, all four updates=1, all flushes=0.
REQ-025 DWAIT with dhit=1 applies RUN rules that cycle and returns to RUN next cycle.
REQ-026 halt_mem=1 in a cycle with memwb_update=1 moves to HALT next cycle; halted=1 from that edge.
REQ-027 HALT: pc_en=0, all updates=0, all flushes=0; exits only by RST.
REQ-028 stall_cnt increments each cycle pc_en=0 outside HALT; saturates at 32'hFFFF_FFFF.
REQ-029 Wait counter (16 bit) clears on entry to DWAIT, increments per DWAIT cycle, clears on leaving DWAIT.

Reset
REQ-030 RST=1 forces immediately: state RUN, halted=0, wd_timeout=0, stall_cnt=0, wait counter=0.
REQ-031 While RST=1: pc_en=0, all updates=0, all flushes=0.
REQ-032 RST asserted mid-DWAIT or in HALT discards all state; first cycle after release follows RUN rules.

Configuration
REQ-033 Macro PIPE_WATCHDOG_EN defined: wait counter reaching WD_LIMIT-1 with dhit=0 sets wd_timeout=1 and moves to HALT (halted=1) next edge.
REQ-034 PIPE_WATCHDOG_EN undefined: no wait counter, wd_timeout tied 0, DWAIT unbounded.

Verification
REQ-035 mem_req=1, dhit=0 for 3 cycles then 1, ihit=1 -> 3 cycles pc_en=0, memwb_flush=1, exmem_update=0; 4th cycle all updates=1; stall_cnt=3.
REQ-036 branch_taken=1, ihit=1 -> ifid/idex/exmem_flush=1, pc_en=1, memwb_update=1 same cycle.
REQ-037 load_use=1, ihit=1 -> pc_en=0, ifid_update=0, idex_flush=1; next cycle (load_use=0) full advance.
REQ-038 halt_mem=1 on advance cycle -> halted=1 next edge; subsequent ihit/mem_req toggling leaves all outputs 0.
REQ-039 PIPE_WATCHDOG_EN, WD_LIMIT=4, mem_req=1, dhit never -> wd_timeout=1, halted=1 after 4th wait cycle.
REQ-040 RST pulsed mid-DWAIT (async, between edges) -> outputs 0 immediately; after release, stall_cnt=0, state RUN.
